hazard3_ahb_arb_nport: RTL
==========================

HAZARD3_AHB_ARB_NPORT -- requirements
Module: hazard3_ahb_arb_nport

Interface
REQ-001 Parameter N_PORTS, default 3: number of requesting masters, 2..8; port 0 has the highest static priority.
REQ-002 Parameter W_ADDR, default 32: address width.
REQ-003 Parameter W_DATA, default 32: data width.
REQ-004 Parameter NO_PIPE_MASK, default 3'b100 (N_PORTS bits): a set bit means that port is never granted while its own data phase is outstanding.
REQ-005 Parameter STARVE_CYCLES, default 16, range 1..255: count of consecutive lost arbitrations after which a port is boosted.
REQ-006 Parameter HMASTER_BASE, default 8'h00: hmaster for port i is HMASTER_BASE+i.
REQ-007 clk  in  1  single clock; all state is sampled on its rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 src_aph_req  in  N_PORTS  per-port address-phase request.
REQ-010 src_haddr / src_hsize / src_hwrite / src_hprot / src_hexcl  in  N_PORTS x (W_ADDR/3/1/4/1)  flattened per-port address-phase attributes.
REQ-011 src_wdata  in  N_PORTS*W_DATA  per-port write data, valid in that port's data phase.
REQ-012 src_aph_ready / src_dph_ready / src_dph_err / src_dph_exokay  out  N_PORTS each  per-port handshake responses.
REQ-013 src_rdata  out  W_DATA  hrdata broadcast to all ports.
REQ-014 haddr, hwrite, htrans[1:0], hsize[2:0], hprot[3:0], hexcl, hmaster[7:0], hburst[2:0], hmastlock, hwdata  out  AHB5 manager outputs.
REQ-015 hready, hresp, hexokay, hrdata  in  AHB5 manager inputs.

Function
REQ-016 hburst SHALL be constant 3'b000 and hmastlock constant 0.
REQ-017 hold SHALL register (htrans[1] && !hready && !hresp) each cycle; while hold=1, the grant SHALL equal the registered previous grant, regardless of requests.
REQ-018 Eligibility: port i is eligible iff src_aph_req[i] && !(NO_PIPE_MASK[i] && dph_active[i]).
REQ-019 With hold=0: the grant goes to the lowest-index boosted eligible port; if no eligible port is boosted, to the lowest-index eligible port; if none is eligible, no grant.
REQ-020 At most one grant bit SHALL be set (one-hot or zero).
REQ-021 Granted: htrans=2'b10 and all attributes come from the granted port; hmaster=HMASTER_BASE+index. Not granted: htrans=2'b00, every other output 0.
REQ-022 src_aph_ready[i] = gnt[i] && hready; the address phase is combinational, with zero-cycle latency from request to htrans.
REQ-023 dph_active[N_PORTS-1:0] SHALL load gnt when hready=1 and hold its value when hready=0.
REQ-024 src_dph_ready[i] = dph_active[i] && hready; src_dph_err[i] = dph_active[i] && hresp, asserted in both error cycles; src_dph_exokay[i] = dph_active[i] && hexokay.
REQ-025 hwdata SHALL be src_wdata of the port with dph_active set, or 0 when there is none.
REQ-026 Error: the first hresp cycle (hready=0) clears hold, so the next cycle re-arbitrates and a queued address phase may be dropped or changed, per AHB5.

Reset
REQ-027 While rst=1: hold=0, previous grant=0, dph_active=0, all starvation counters=0, htrans=IDLE, every src_* response=0, hwdata=0.
REQ-028 Assertion of rst mid-transfer SHALL abandon all state immediately, with no completion signalled to any port.

Configuration
REQ-029 Macro HAZARD3_ARB_STARVE_EN compiled in: per-port saturating counter, 8 bits wide.
- Increments when the port is eligible, hold=0, hready=1 and it is not granted.
- Clears when gnt[i] && hready.
- The port is boosted while its counter >= STARVE_CYCLES.
REQ-030 Without HAZARD3_ARB_STARVE_EN: no counters exist, no port is ever boosted, and arbitration is pure static priority.

Verification
REQ-031 Ports 0 and 2 request together, hready=1 -> port 0 granted, htrans=2'b10, hmaster=8'h00; next cycle dph_active=3'b001.
REQ-032 Port 1 granted with hready=0 for 3 cycles while port 0 requests -> grant stays on port 1 for all 3 cycles; port 0 is granted in the cycle after hready returns to 1.
REQ-033 Port 2 holds a data phase with hready=0 and keeps requesting -> port 2 is not granted until its src_dph_ready pulses (NO_PIPE_MASK).
REQ-034 Two-cycle error on port 1 (hresp=1, hready=0, then hresp=1, hready=1) -> src_dph_err[1]=1 in both cycles and hold=0 in the second cycle.
REQ-035 With the macro compiled in and STARVE_CYCLES=4: port 0 requests every cycle and port 1 requests continuously -> port 1 granted in the 5th cycle; with the macro compiled out, port 1 is never granted.
REQ-036 rst pulsed during port 0's data phase -> all outputs read 0 and htrans=IDLE in that same cycle; the first grant after rst deasserts follows static priority.

Source files
------------

// File: rtl/hazard3_ahb_arb_nport.sv
// ============================================================================
// hazard3_ahb_arb_nport
//
// Purpose:
//   N-port AHB5 manager arbiter. Several requesting masters are merged onto
//   one AHB5 manager port. Arbitration is static priority: port 0 is the
//   highest priority. The address phase is combinational, so a request
//   reaches htrans in the same cycle it is raised. A registered hold flag
//   keeps the grant stable while a stalled address phase is pending.
//   The data phase is tracked per port so that responses and write data
//   reach the correct master.
//
// Optional feature:
//   `define HAZARD3_ARB_STARVE_EN
//     Adds an 8-bit saturating starvation counter per port. A port that
//     has lost STARVE_CYCLES consecutive arbitrations is boosted above
//     static priority. When the macro is undefined, arbitration is pure
//     static priority and no counters exist.
//
// Parameters:
//   N_PORTS        number of masters (2..8)
//   W_ADDR/W_DATA  address / data width
//   NO_PIPE_MASK   set bit: that port is never granted while its own data
//                  phase is outstanding
//   STARVE_CYCLES  boost threshold (1..255)
//   HMASTER_BASE   hmaster value for port 0; port i drives HMASTER_BASE+i
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   src_aph_req                   per-port address-phase request
//   src_haddr/hsize/hwrite/hprot/hexcl
//                                 flattened per-port address attributes
//   src_wdata                     flattened per-port write data
//   src_aph_ready/src_dph_ready/src_dph_err/src_dph_exokay
//                                 per-port handshake responses
//   src_rdata                     hrdata broadcast to all ports
//   haddr..hwdata                 AHB5 manager outputs
//   hready, hresp, hexokay, hrdata
//                                 AHB5 manager inputs
// ============================================================================
module hazard3_ahb_arb_nport #(
    parameter int unsigned          N_PORTS       = 3,
    parameter int unsigned          W_ADDR        = 32,
    parameter int unsigned          W_DATA        = 32,
    parameter logic [N_PORTS-1:0]   NO_PIPE_MASK  = 3'b100,
    parameter int unsigned          STARVE_CYCLES = 16,
    parameter logic [7:0]           HMASTER_BASE  = 8'h00
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [N_PORTS-1:0]          src_aph_req,
    input  logic [N_PORTS*W_ADDR-1:0]   src_haddr,
    input  logic [N_PORTS*3-1:0]        src_hsize,
    input  logic [N_PORTS-1:0]          src_hwrite,
    input  logic [N_PORTS*4-1:0]        src_hprot,
    input  logic [N_PORTS-1:0]          src_hexcl,
    input  logic [N_PORTS*W_DATA-1:0]   src_wdata,

    output logic [N_PORTS-1:0]          src_aph_ready,
    output logic [N_PORTS-1:0]          src_dph_ready,
    output logic [N_PORTS-1:0]          src_dph_err,
    output logic [N_PORTS-1:0]          src_dph_exokay,
    output logic [W_DATA-1:0]           src_rdata,

    output logic [W_ADDR-1:0]           haddr,
    output logic                        hwrite,
    output logic [1:0]                  htrans,
    output logic [2:0]                  hsize,
    output logic [3:0]                  hprot,
    output logic                        hexcl,
    output logic [7:0]                  hmaster,
    output logic [2:0]                  hburst,
    output logic                        hmastlock,
    output logic [W_DATA-1:0]           hwdata,

    input  logic                        hready,
    input  logic                        hresp,
    input  logic                        hexokay,
    input  logic [W_DATA-1:0]           hrdata
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity check
    // ------------------------------------------------------------------------
    localparam bit PARAMS_OK = (N_PORTS >= 2) && (N_PORTS <= 8) &&
                               (STARVE_CYCLES >= 1) && (STARVE_CYCLES <= 255);

    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("hazard3_ahb_arb_nport: N_PORTS or STARVE_CYCLES out of range");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                   r_hold;        // stalled address phase pending
    logic [N_PORTS-1:0]     r_gnt_prev;    // grant of the previous cycle
    logic [N_PORTS-1:0]     r_dph_active;  // one-hot owner of the data phase

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic [N_PORTS-1:0]     w_elig;
    logic [N_PORTS-1:0]     w_boost;
    logic [N_PORTS-1:0]     w_cand_boost;
    logic [N_PORTS-1:0]     w_pick_boost;
    logic [N_PORTS-1:0]     w_pick_elig;
    logic [N_PORTS-1:0]     w_gnt_arb;
    logic [N_PORTS-1:0]     w_gnt;

    genvar gi;

    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_elig
            // A no-pipe port must wait for its own data phase to retire.
            assign w_elig[gi] = src_aph_req[gi] &&
                                !(NO_PIPE_MASK[gi] && r_dph_active[gi]);
        end
    endgenerate

`ifdef HAZARD3_ARB_STARVE_EN
    localparam logic [7:0] STARVE_THRESH = 8'(STARVE_CYCLES);

    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_starve
            logic [7:0] r_starve_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_starve_cnt <= 8'h00;
                end else if (w_gnt[gi] && hready) begin
                    r_starve_cnt <= 8'h00;
                end else if (w_elig[gi] && !r_hold && hready && !w_gnt[gi] &&
                             (r_starve_cnt != 8'hff)) begin
                    r_starve_cnt <= r_starve_cnt + 8'h01;
                end
            end

            assign w_boost[gi] = (r_starve_cnt >= STARVE_THRESH);
        end
    endgenerate
`else
    assign w_boost = '0;
`endif

    // x & -x isolates the lowest set bit, i.e. the highest-priority port.
    assign w_cand_boost = w_elig & w_boost;
    assign w_pick_boost = w_cand_boost & (~w_cand_boost + 1'b1);
    assign w_pick_elig  = w_elig & (~w_elig + 1'b1);
    assign w_gnt_arb    = (|w_cand_boost) ? w_pick_boost : w_pick_elig;

    // While a stalled address phase is pending the grant must not move.
    // Reset suppresses the combinational grant so htrans reads IDLE at once.
    assign w_gnt = rst    ? '0 :
                   r_hold ? r_gnt_prev : w_gnt_arb;

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold       <= 1'b0;
            r_gnt_prev   <= '0;
            r_dph_active <= '0;
        end else begin
            // An error response's first cycle (hresp=1) releases the hold
            // so the pending address phase can be re-arbitrated.
            r_hold     <= (|w_gnt) && !hready && !hresp;
            r_gnt_prev <= w_gnt;
            if (hready) begin
                r_dph_active <= w_gnt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Address-phase mux (AND-OR over a one-hot grant)
    // ------------------------------------------------------------------------
    logic [W_ADDR-1:0]  w_addr_m   [N_PORTS];
    logic [2:0]         w_size_m   [N_PORTS];
    logic [3:0]         w_prot_m   [N_PORTS];
    logic [7:0]         w_mst_m    [N_PORTS];
    logic [W_DATA-1:0]  w_wdata_m  [N_PORTS];

    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_mux
            assign w_addr_m[gi]  = w_gnt[gi] ? src_haddr[gi*W_ADDR +: W_ADDR] : '0;
            assign w_size_m[gi]  = w_gnt[gi] ? src_hsize[gi*3 +: 3] : 3'b000;
            assign w_prot_m[gi]  = w_gnt[gi] ? src_hprot[gi*4 +: 4] : 4'b0000;
            assign w_mst_m[gi]   = w_gnt[gi] ? (HMASTER_BASE + 8'(gi)) : 8'h00;
            assign w_wdata_m[gi] = r_dph_active[gi] ?
                                   src_wdata[gi*W_DATA +: W_DATA] : '0;
        end
    endgenerate

    always_comb begin
        haddr   = '0;
        hsize   = 3'b000;
        hprot   = 4'b0000;
        hmaster = 8'h00;
        hwdata  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            haddr   = haddr   | w_addr_m[i];
            hsize   = hsize   | w_size_m[i];
            hprot   = hprot   | w_prot_m[i];
            hmaster = hmaster | w_mst_m[i];
            hwdata  = hwdata  | w_wdata_m[i];
        end
    end

    assign hwrite    = |(w_gnt & src_hwrite);
    assign hexcl     = |(w_gnt & src_hexcl);
    assign htrans    = {(|w_gnt), 1'b0};
    assign hburst    = 3'b000;
    assign hmastlock = 1'b0;

    // ------------------------------------------------------------------------
    // Per-port responses
    // ------------------------------------------------------------------------
    assign src_aph_ready  = w_gnt & {N_PORTS{hready}};
    assign src_dph_ready  = r_dph_active & {N_PORTS{hready}};
    assign src_dph_err    = r_dph_active & {N_PORTS{hresp}};
    assign src_dph_exokay = r_dph_active & {N_PORTS{hexokay}};
    assign src_rdata      = rst ? '0 : hrdata;

endmodule
